// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and main-memory ports around mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and memory.
interface mem_arbiter_if;
    logic        icache_re;
    logic [31:0] icache_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_dout;

    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_din;
    logic        dcache_req_ready;
    logic        dcache_resp_valid;
    logic [31:0] dcache_dout;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  icache_re, icache_addr,
        output icache_req_ready, icache_resp_valid, icache_dout,
        input  dcache_re, dcache_we, dcache_addr, dcache_din,
        output dcache_req_ready, dcache_resp_valid, dcache_dout,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output icache_re, icache_addr,
        input  icache_req_ready, icache_resp_valid, icache_dout,
        output dcache_re, dcache_we, dcache_addr, dcache_din,
        input  dcache_req_ready, dcache_resp_valid, dcache_dout,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter in front of a single-outstanding main memory port.
// Simultaneous requests are both captured; the loser is issued right after the winner.
module mem_arbiter #(
    parameter bit DPRIO = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic        i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic        cur_q, cur_d;
    logic        rr_q, rr_d;
    logic        i_rv_q, i_rv_d, d_rv_q, d_rv_d;
    logic [31:0] i_dout_q, i_dout_d, d_dout_q, d_dout_d;
    logic [31:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d, d_data_q, d_data_d;
    logic [3:0]  d_mask_q, d_mask_d;
    logic        d_wr_q, d_wr_d;
    logic        accept, i_acc, d_acc, d_wr_in, done, win;

    always_comb begin
        state_d  = state_q;
        i_pend_d = i_pend_q;
        d_pend_d = d_pend_q;
        cur_d    = cur_q;
        rr_d     = rr_q;
        i_rv_d   = 1'b0;
        d_rv_d   = 1'b0;
        i_dout_d = i_dout_q;
        d_dout_d = d_dout_q;
        i_addr_d = i_addr_q;
        d_addr_d = d_addr_q;
        d_data_d = d_data_q;
        d_mask_d = d_mask_q;
        d_wr_d   = d_wr_q;
        done     = 1'b0;
        win      = 1'b0;

        accept  = (state_q == IDLE) && !i_pend_q && !d_pend_q;
        d_wr_in = |bus.dcache_we;
        i_acc   = accept && bus.icache_re;
        d_acc   = accept && (bus.dcache_re || d_wr_in);

        case (state_q)
            IDLE: begin
                if (i_acc) i_addr_d = bus.icache_addr;
                if (d_acc) begin
                    d_addr_d = bus.dcache_addr;
                    d_data_d = bus.dcache_din;
                    d_mask_d = bus.dcache_we;
                    d_wr_d   = d_wr_in;
                end
                // cur/win: 0 selects icache, 1 selects dcache
                if (i_acc && d_acc) begin
                    win      = DPRIO ? 1'b1 : rr_q;
                    rr_d     = DPRIO ? rr_q : ~rr_q;
                    cur_d    = win;
                    i_pend_d = win;
                    d_pend_d = ~win;
                    state_d  = ISSUE;
                end else if (i_acc || d_acc) begin
                    cur_d   = d_acc;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    if (cur_q && d_wr_q) done = 1'b1;
                    else                 state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (cur_q) begin
                        d_dout_d = bus.mem_resp_data;
                        d_rv_d   = 1'b1;
                    end else begin
                        i_dout_d = bus.mem_resp_data;
                        i_rv_d   = 1'b1;
                    end
                    done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A captured loser goes straight to ISSUE, bypassing the accepting IDLE.
        if (done) begin
            if (i_pend_q) begin
                cur_d    = 1'b0;
                i_pend_d = 1'b0;
                state_d  = ISSUE;
            end else if (d_pend_q) begin
                cur_d    = 1'b1;
                d_pend_d = 1'b0;
                state_d  = ISSUE;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            i_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
            cur_q    <= 1'b0;
            rr_q     <= 1'b0;
            i_rv_q   <= 1'b0;
            d_rv_q   <= 1'b0;
            i_dout_q <= NOP;
            d_dout_q <= NOP;
        end else begin
            state_q  <= state_d;
            i_pend_q <= i_pend_d;
            d_pend_q <= d_pend_d;
            cur_q    <= cur_d;
            rr_q     <= rr_d;
            i_rv_q   <= i_rv_d;
            d_rv_q   <= d_rv_d;
            i_dout_q <= i_dout_d;
            d_dout_q <= d_dout_d;
        end
    end

    always_ff @(posedge clk) begin
        i_addr_q <= i_addr_d;
        d_addr_q <= d_addr_d;
        d_data_q <= d_data_d;
        d_mask_q <= d_mask_d;
        d_wr_q   <= d_wr_d;
    end

    assign bus.icache_req_ready  = accept && !reset;
    assign bus.dcache_req_ready  = accept && !reset;
    assign bus.icache_resp_valid = i_rv_q;
    assign bus.dcache_resp_valid = d_rv_q;
    assign bus.icache_dout       = i_dout_q;
    assign bus.dcache_dout       = d_dout_q;

    // Request fields come from holding registers, so they cannot move during a stall.
    assign bus.mem_req_valid = (state_q == ISSUE) && !reset;
    assign bus.mem_req_rw    = cur_q && d_wr_q;
    assign bus.mem_req_addr  = cur_q ? d_addr_q : i_addr_q;
    assign bus.mem_req_data  = cur_q ? d_data_q : 32'h0;
    assign bus.mem_req_mask  = cur_q ? d_mask_q : 4'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with dcache priority, one with round-robin,
// each backed by a small behavioural memory responding on the falling edge.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bp ();
    mem_arbiter_if br ();

    mem_arbiter #(.DPRIO(1'b1)) u_dut_p (.clk(clk), .reset(reset), .bus(bp));
    mem_arbiter #(.DPRIO(1'b0)) u_dut_r (.clk(clk), .reset(reset), .bus(br));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the priority instance: configurable stall and response delay.
    int          p_ready_delay = 0;
    int          p_resp_delay  = 1;
    int          p_stall       = 0;
    int          p_cnt         = 0;
    logic [31:0] p_resp_data   = 32'h0;
    logic [31:0] p_log_addr[$];
    logic [31:0] p_log_data[$];
    logic [3:0]  p_log_mask[$];
    logic        p_log_rw[$];

    always @(negedge clk) begin
        bp.mem_req_ready  = 1'b0;
        bp.mem_resp_valid = 1'b0;
        if (p_cnt > 0) begin
            p_cnt = p_cnt - 1;
            if (p_cnt == 0) begin
                bp.mem_resp_valid = 1'b1;
                bp.mem_resp_data  = p_resp_data;
            end
        end else if (bp.mem_req_valid === 1'b1) begin
            if (p_stall < p_ready_delay) begin
                p_stall = p_stall + 1;
            end else begin
                bp.mem_req_ready = 1'b1;
                p_stall = 0;
                p_log_addr.push_back(bp.mem_req_addr);
                p_log_data.push_back(bp.mem_req_data);
                p_log_mask.push_back(bp.mem_req_mask);
                p_log_rw.push_back(bp.mem_req_rw);
                if (bp.mem_req_rw === 1'b0) p_cnt = p_resp_delay;
            end
        end
    end

    // Memory behind the round-robin instance: always ready, data = ~addr one cycle later.
    int          r_cnt = 0;
    logic [31:0] r_resp_data = 32'h0;
    logic [31:0] r_log_addr[$];

    always @(negedge clk) begin
        br.mem_req_ready  = 1'b0;
        br.mem_resp_valid = 1'b0;
        if (r_cnt > 0) begin
            r_cnt = r_cnt - 1;
            if (r_cnt == 0) begin
                br.mem_resp_valid = 1'b1;
                br.mem_resp_data  = r_resp_data;
            end
        end else if (br.mem_req_valid === 1'b1) begin
            br.mem_req_ready = 1'b1;
            r_log_addr.push_back(br.mem_req_addr);
            if (br.mem_req_rw === 1'b0) begin
                r_cnt       = 1;
                r_resp_data = ~br.mem_req_addr;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_p_log();
        p_log_addr.delete();
        p_log_data.delete();
        p_log_mask.delete();
        p_log_rw.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bp.icache_req_ready, bp.dcache_req_ready, br.icache_req_ready, br.dcache_req_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready got %b%b%b%b want 0000", bp.icache_req_ready,
                     bp.dcache_req_ready, br.icache_req_ready, br.dcache_req_ready);
        end
        checks++;
        if ({bp.mem_req_valid, br.mem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mem_req_valid got %b%b want 00", bp.mem_req_valid, br.mem_req_valid);
        end
        checks++;
        if ({bp.icache_resp_valid, bp.dcache_resp_valid, br.icache_resp_valid, br.dcache_resp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_resp_valid got %b%b%b%b want 0000", bp.icache_resp_valid,
                     bp.dcache_resp_valid, br.icache_resp_valid, br.dcache_resp_valid);
        end
        checks++;
        if (bp.icache_dout !== 32'h0000_0013 || br.icache_dout !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reset_icache_dout got %h/%h want 00000013", bp.icache_dout, br.icache_dout);
        end
        checks++;
        if (bp.dcache_dout !== 32'h0000_0013 || br.dcache_dout !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reset_dcache_dout got %h/%h want 00000013", bp.dcache_dout, br.dcache_dout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bp.icache_req_ready, bp.dcache_req_ready, br.icache_req_ready, br.dcache_req_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL post_reset_req_ready got %b%b%b%b want 1111", bp.icache_req_ready,
                     bp.dcache_req_ready, br.icache_req_ready, br.dcache_req_ready);
        end
    endtask

    task automatic test_icache_read();
        int ip = 0;
        int dp = 0;
        int lat = -1;
        clear_p_log();
        p_resp_delay = 2;
        p_resp_data  = 32'hDEAD_BEEF;
        bp.icache_re   = 1'b1;
        bp.icache_addr = 32'h0000_1000;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) bp.icache_re = 1'b0;
            if (bp.icache_resp_valid === 1'b1) begin
                ip++;
                if (lat < 0) lat = c;
            end
            if (bp.dcache_resp_valid === 1'b1) dp++;
        end
        checks++;
        if (ip != 1) begin errors++; $display("FAIL iread_pulses got %0d want 1", ip); end
        checks++;
        if (dp != 0) begin errors++; $display("FAIL iread_dcache_pulses got %0d want 0", dp); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL iread_latency got %0d want 4", lat); end
        checks++;
        if (bp.icache_dout !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL iread_dout got %h want deadbeef", bp.icache_dout);
        end
        checks++;
        if (p_log_addr.size() != 1 || p_log_addr[0] !== 32'h0000_1000 || p_log_rw[0] !== 1'b0) begin
            errors++; $display("FAIL iread_mem_req got %0d reqs want 1 read of 00001000", p_log_addr.size());
        end
    endtask

    task automatic test_min_latency();
        int ip = 0;
        int dp = 0;
        int lat = -1;
        clear_p_log();
        p_resp_delay = 1;
        p_resp_data  = 32'h00C0_FFEE;
        bp.dcache_re   = 1'b1;
        bp.dcache_addr = 32'h0000_1400;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) bp.dcache_re = 1'b0;
            if (bp.dcache_resp_valid === 1'b1) begin
                dp++;
                if (lat < 0) lat = c;
            end
            if (bp.icache_resp_valid === 1'b1) ip++;
        end
        checks++;
        if (lat != 3 || dp != 1) begin
            errors++; $display("FAIL dread_latency got lat=%0d pulses=%0d want lat=3 pulses=1", lat, dp);
        end
        checks++;
        if (bp.dcache_dout !== 32'h00C0_FFEE) begin
            errors++; $display("FAIL dread_dout got %h want 00c0ffee", bp.dcache_dout);
        end
        checks++;
        if (ip != 0 || bp.icache_dout !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dread_icache_hold got pulses=%0d dout=%h want 0/deadbeef", ip, bp.icache_dout);
        end
    endtask

    task automatic test_simultaneous();
        int ip = 0;
        int dp = 0;
        int lat = -1;
        int rdy = -1;
        clear_p_log();
        p_resp_delay = 1;
        p_resp_data  = 32'h7777_1111;
        bp.icache_re   = 1'b1;
        bp.icache_addr = 32'h0000_2000;
        bp.dcache_re   = 1'b1;
        bp.dcache_we   = 4'b0011;
        bp.dcache_addr = 32'h0000_3000;
        bp.dcache_din  = 32'h1234_5678;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                bp.icache_re = 1'b0;
                bp.dcache_re = 1'b0;
                bp.dcache_we = 4'b0000;
            end
            if (bp.icache_resp_valid === 1'b1) begin
                ip++;
                if (lat < 0) lat = c;
            end
            if (bp.dcache_resp_valid === 1'b1) dp++;
            if (bp.icache_req_ready === 1'b1 && rdy < 0) rdy = c;
        end
        checks++;
        if (ip != 1 || lat != 4) begin
            errors++; $display("FAIL simul_icache_resp got pulses=%0d lat=%0d want 1/4", ip, lat);
        end
        checks++;
        if (dp != 0) begin errors++; $display("FAIL simul_write_no_resp got %0d want 0", dp); end
        checks++;
        if (rdy != 4) begin errors++; $display("FAIL simul_ready_return got cycle %0d want 4", rdy); end
        checks++;
        if (bp.icache_dout !== 32'h7777_1111) begin
            errors++; $display("FAIL simul_icache_dout got %h want 77771111", bp.icache_dout);
        end
        checks++;
        if (p_log_addr.size() != 2) begin
            errors++; $display("FAIL simul_req_count got %0d want 2", p_log_addr.size());
        end else begin
            checks++;
            if (p_log_addr[0] !== 32'h0000_3000 || p_log_rw[0] !== 1'b1) begin
                errors++; $display("FAIL simul_first_req got addr=%h rw=%b want 00003000/1", p_log_addr[0], p_log_rw[0]);
            end
            checks++;
            if (p_log_mask[0] !== 4'b0011 || p_log_data[0] !== 32'h1234_5678) begin
                errors++; $display("FAIL simul_write_fields got mask=%b data=%h want 0011/12345678",
                                   p_log_mask[0], p_log_data[0]);
            end
            checks++;
            if (p_log_addr[1] !== 32'h0000_2000 || p_log_rw[1] !== 1'b0) begin
                errors++; $display("FAIL simul_second_req got addr=%h rw=%b want 00002000/0", p_log_addr[1], p_log_rw[1]);
            end
        end
    endtask

    task automatic test_stall();
        int ip = 0;
        int dp = 0;
        int lat = -1;
        clear_p_log();
        p_ready_delay = 5;
        p_resp_delay  = 1;
        p_resp_data   = 32'hA5A5_5A5A;
        bp.dcache_re   = 1'b1;
        bp.dcache_addr = 32'h0000_4000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                bp.dcache_re   = 1'b0;
                bp.icache_re   = 1'b1;
                bp.icache_addr = 32'h0000_7000;
            end
            if (c == 6) bp.icache_re = 1'b0;
            if (c <= 5) begin
                checks++;
                if (bp.mem_req_valid !== 1'b1 || bp.mem_req_addr !== 32'h0000_4000 || bp.mem_req_rw !== 1'b0 ||
                    bp.icache_req_ready !== 1'b0 || bp.dcache_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_cycle%0d got valid=%b addr=%h rw=%b rdy=%b%b want 1/00004000/0/00", c,
                             bp.mem_req_valid, bp.mem_req_addr, bp.mem_req_rw, bp.icache_req_ready, bp.dcache_req_ready);
                end
            end
            if (bp.dcache_resp_valid === 1'b1) begin
                dp++;
                if (lat < 0) lat = c;
            end
            if (bp.icache_resp_valid === 1'b1) ip++;
        end
        p_ready_delay = 0;
        checks++;
        if (dp != 1 || lat != 8) begin
            errors++; $display("FAIL stall_resp got pulses=%0d lat=%0d want 1/8", dp, lat);
        end
        checks++;
        if (bp.dcache_dout !== 32'hA5A5_5A5A) begin
            errors++; $display("FAIL stall_dout got %h want a5a55a5a", bp.dcache_dout);
        end
        checks++;
        if (ip != 0 || p_log_addr.size() != 1) begin
            errors++; $display("FAIL stall_no_capture got ipulses=%0d reqs=%0d want 0/1", ip, p_log_addr.size());
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr[6];
        int ip_tot = 0;
        int dp_tot = 0;
        r_log_addr.delete();
        exp_addr[0] = 32'h0000_0100; exp_addr[1] = 32'h0000_0800;
        exp_addr[2] = 32'h0000_0810; exp_addr[3] = 32'h0000_0110;
        exp_addr[4] = 32'h0000_0120; exp_addr[5] = 32'h0000_0820;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            int ip = 0;
            int dp = 0;
            while (!(br.icache_req_ready === 1'b1 && br.dcache_req_ready === 1'b1) && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 20) begin errors++; $display("FAIL rr_ready_timeout pair %0d got none want ready", k); end
            br.icache_re   = 1'b1;
            br.icache_addr = 32'h0000_0100 + 32'(k * 16);
            br.dcache_re   = 1'b1;
            br.dcache_addr = 32'h0000_0800 + 32'(k * 16);
            tick();
            br.icache_re = 1'b0;
            br.dcache_re = 1'b0;
            n = 0;
            while ((ip == 0 || dp == 0) && n < 20) begin
                if (br.icache_resp_valid === 1'b1) ip++;
                if (br.dcache_resp_valid === 1'b1) dp++;
                if (ip == 0 || dp == 0) begin
                    tick();
                    n++;
                end
            end
            ip_tot += ip;
            dp_tot += dp;
        end
        checks++;
        if (ip_tot != 3 || dp_tot != 3) begin
            errors++; $display("FAIL rr_pulses got i=%0d d=%0d want 3/3", ip_tot, dp_tot);
        end
        checks++;
        if (r_log_addr.size() != 6) begin
            errors++; $display("FAIL rr_req_count got %0d want 6", r_log_addr.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (r_log_addr[j] !== exp_addr[j]) begin
                    errors++; $display("FAIL rr_grant%0d got %h want %h", j, r_log_addr[j], exp_addr[j]);
                end
            end
        end
        checks++;
        if (br.icache_dout !== ~32'h0000_0120 || br.dcache_dout !== ~32'h0000_0820) begin
            errors++; $display("FAIL rr_dout got %h/%h want %h/%h", br.icache_dout, br.dcache_dout,
                               ~32'h0000_0120, ~32'h0000_0820);
        end
    endtask

    task automatic test_reset_mid();
        int ip = 0;
        int dp = 0;
        int lat = -1;
        clear_p_log();
        p_resp_delay = 6;
        p_resp_data  = 32'hFEED_FACE;
        bp.icache_re   = 1'b1;
        bp.icache_addr = 32'h0000_5000;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) bp.icache_re = 1'b0;
            if (c == 3) reset = 1'b1;
            if (c == 5) reset = 1'b0;
            if (bp.icache_resp_valid === 1'b1) ip++;
            if (bp.dcache_resp_valid === 1'b1) dp++;
        end
        checks++;
        if (ip != 0 || dp != 0) begin
            errors++; $display("FAIL rst_mid_resp got i=%0d d=%0d want 0/0", ip, dp);
        end
        checks++;
        if (bp.icache_dout !== 32'h0000_0013 || bp.dcache_dout !== 32'h0000_0013) begin
            errors++; $display("FAIL rst_mid_dout got %h/%h want 00000013", bp.icache_dout, bp.dcache_dout);
        end
        checks++;
        if (bp.dcache_req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ready got %b want 1", bp.dcache_req_ready);
        end
        p_resp_delay   = 1;
        p_resp_data    = 32'h0BAD_F00D;
        bp.dcache_re   = 1'b1;
        bp.dcache_addr = 32'h0000_6000;
        dp = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) bp.dcache_re = 1'b0;
            if (bp.dcache_resp_valid === 1'b1) begin
                dp++;
                if (lat < 0) lat = c;
            end
        end
        checks++;
        if (dp != 1 || lat != 3 || bp.dcache_dout !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL rst_mid_next got pulses=%0d lat=%0d dout=%h want 1/3/0badf00d", dp, lat, bp.dcache_dout);
        end
    endtask

    initial begin
        reset = 1'b1;
        bp.icache_re = 1'b0; bp.icache_addr = 32'h0;
        bp.dcache_re = 1'b0; bp.dcache_we = 4'h0; bp.dcache_addr = 32'h0; bp.dcache_din = 32'h0;
        br.icache_re = 1'b0; br.icache_addr = 32'h0;
        br.dcache_re = 1'b0; br.dcache_we = 4'h0; br.dcache_addr = 32'h0; br.dcache_din = 32'h0;
        test_reset();
        test_icache_read();
        test_min_latency();
        test_simultaneous();
        test_stall();
        test_round_robin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
